// File: rtl/mem_io_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_responder_pkg
//  Description : Shared constants, types and the read-address decoder for the
//                memory-mapped I/O responder (UART byte streams, cycle
//                counter, halt request).
//  Contents    : FIFO_W   - byte width carried by both FIFOs
//                CNT_W    - cycle counter width
//                IO_BASE  - UART data register (read pops rx, write pushes tx)
//                IO_CLK   - cycle counter snapshot / halt register
//                rd_sel_e - what an accepted read returns
//                decode_rd- maps a decoded I/O address to rd_sel_e
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_io_responder_pkg;

  localparam int FIFO_W = 8;
  localparam int CNT_W  = 32;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_CLK  = 18'h30004;

  // Source of the byte returned for an accepted read. RSEL_NONE means no
  // I/O read happened; RSEL_ZERO is an I/O read of an unmapped offset.
  typedef enum logic [2:0] {
    RSEL_NONE = 3'd0,
    RSEL_ZERO = 3'd1,
    RSEL_RX   = 3'd2,
    RSEL_CNT0 = 3'd3,
    RSEL_CNT1 = 3'd4,
    RSEL_CNT2 = 3'd5,
    RSEL_CNT3 = 3'd6
  } rd_sel_e;

  function automatic rd_sel_e decode_rd(input logic [17:0] addr);
    rd_sel_e sel;
    sel = RSEL_ZERO;
    if (addr == IO_BASE)               sel = RSEL_RX;
    else if (addr == IO_CLK)           sel = RSEL_CNT0;
    else if (addr == IO_CLK + 18'd1)   sel = RSEL_CNT1;
    else if (addr == IO_CLK + 18'd2)   sel = RSEL_CNT2;
    else if (addr == IO_CLK + 18'd3)   sel = RSEL_CNT3;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_responder_if
//  Description : Bundle of the CPU bus and the two UART byte streams seen by
//                the I/O responder.
//  Signals     : mem_a/mem_dout/mem_wr     CPU address, write byte, direction
//                io_din/io_rd_hit          read byte and its valid strobe
//                io_buffer_full            CPU must stall I/O writes
//                tx_data/tx_valid/tx_ready byte stream towards the transmitter
//                rx_data/rx_valid/rx_ready byte stream from the receiver
//  Modports    : master - CPU and UART side; slave - the responder
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  logic [31:0]       mem_a;
  logic [FIFO_W-1:0] mem_dout;
  logic              mem_wr;
  logic [FIFO_W-1:0] io_din;
  logic              io_rd_hit;
  logic              io_buffer_full;
  logic [FIFO_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [FIFO_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    input  io_din, io_rd_hit, io_buffer_full, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    output io_din, io_rd_hit, io_buffer_full, tx_data, tx_valid, rx_ready
  );

endinterface
`default_nettype wire

// File: rtl/sync_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_byte_fifo
//  Description : Single-clock FIFO with registered pointers and occupancy.
//                Push on full and pop on empty are ignored; a simultaneous
//                accepted push and pop leaves the count unchanged.
//  Ports       : clk_i     clock
//                rst_n_i   synchronous active-low reset (empties the FIFO)
//                push_i    write din_i when not full
//                pop_i     advance past the head when not empty
//                din_i     write data
//                dout_o    head entry (valid while !empty_o)
//                full_o    count == DEPTH
//                empty_o   count == 0
//                count_o   occupancy, log2(DEPTH)+1 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = FIFO_W
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok_w, pop_ok_w;

  assign full_o    = (count_q == C_DEPTH);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign dout_o    = mem_q[rd_ptr_q];
  assign push_ok_w = push_i && !full_o;
  assign pop_ok_w  = pop_i && !empty_o;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok_w) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok_w, pop_ok_w})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_responder
//  Description : Memory-mapped I/O responder. Decodes CPU accesses with
//                mem_a[17:16]==2'b11, moves bytes to/from the UART through
//                two FIFOs, exposes a free-running cycle counter through a
//                little-endian snapshot and latches a halt request.
//  Ports       : clk_in          system clock
//                rst_in          synchronous active-low reset
//                rdy_in          global enable; low freezes all state
//                bus             CPU bus + UART streams (slave modport)
//                program_stop    sticky halt request
//                tx_overflow_o   sticky: an I/O write hit a full tx FIFO
//                dbg_cnt_load_i  load the cycle counter (enabled edges only)
//                dbg_cnt_val_i   value loaded into the cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 8,
  parameter int FULL_MARGIN = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  mem_io_responder_if.slave    bus,
  output logic                 program_stop,
  output logic                 tx_overflow_o,
  input  logic                 dbg_cnt_load_i,
  input  logic [CNT_W-1:0]     dbg_cnt_val_i
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam logic [TX_CW-1:0] TX_FULL_THR = TX_CW'(TX_DEPTH - FULL_MARGIN);

  // ---------------------------------------------------------------- decode
  logic [17:0] addr_w;
  logic        io_acc_w, io_rd_w, io_wr_w;
  rd_sel_e     rd_sel_w;
  logic        unused_addr_hi_w;

  assign addr_w           = bus.mem_a[17:0];
  assign unused_addr_hi_w = ^bus.mem_a[31:18];
  assign io_acc_w         = rdy_in && (addr_w[17:16] == 2'b11);
  assign io_rd_w          = io_acc_w && !bus.mem_wr;
  assign io_wr_w          = io_acc_w && bus.mem_wr;
  assign rd_sel_w         = io_rd_w ? decode_rd(addr_w) : RSEL_NONE;

  // ---------------------------------------------------------------- tx path
  logic              tx_req_w, tx_push_w, tx_pop_w, tx_full_w, tx_empty_w;
  logic              tx_valid_w;
  logic [FIFO_W-1:0] tx_din_w, tx_head_w;
  logic [TX_CW-1:0]  tx_count_w;

  // A halt request enqueues a 0x00 marker byte; data writes of 0x00 are
  // dropped so the marker is unambiguous on the stream.
  assign tx_req_w  = io_wr_w && (((addr_w == IO_BASE) && (bus.mem_dout != '0))
                                 || (addr_w == IO_CLK));
  assign tx_din_w  = (addr_w == IO_CLK) ? '0 : bus.mem_dout;
  assign tx_push_w = tx_req_w && !tx_full_w;
  // Streams are only advertised while enabled, so a handshake can never
  // complete on an edge where the FIFO is frozen.
  assign tx_valid_w = !tx_empty_w && rdy_in;
  assign tx_pop_w   = tx_valid_w && bus.tx_ready;

  sync_byte_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (FIFO_W)
  ) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_n_i (rst_in),
    .push_i  (tx_push_w),
    .pop_i   (tx_pop_w),
    .din_i   (tx_din_w),
    .dout_o  (tx_head_w),
    .full_o  (tx_full_w),
    .empty_o (tx_empty_w),
    .count_o (tx_count_w)
  );

  assign bus.tx_valid       = tx_valid_w;
  assign bus.tx_data        = tx_head_w;
  assign bus.io_buffer_full = (tx_count_w >= TX_FULL_THR);

  // ---------------------------------------------------------------- rx path
  logic              rx_push_w, rx_pop_w, rx_full_w, rx_empty_w, rx_ready_w;
  logic [FIFO_W-1:0] rx_head_w;
  logic [RX_CW-1:0]  unused_rx_count_w;

  assign rx_ready_w = !rx_full_w && rdy_in;
  assign rx_push_w  = bus.rx_valid && rx_ready_w;
  assign rx_pop_w   = (rd_sel_w == RSEL_RX) && !rx_empty_w;

  sync_byte_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (FIFO_W)
  ) u_rx_fifo (
    .clk_i   (clk_in),
    .rst_n_i (rst_in),
    .push_i  (rx_push_w),
    .pop_i   (rx_pop_w),
    .din_i   (bus.rx_data),
    .dout_o  (rx_head_w),
    .full_o  (rx_full_w),
    .empty_o (rx_empty_w),
    .count_o (unused_rx_count_w)
  );

  assign bus.rx_ready = rx_ready_w;

  // ------------------------------------------------ counter, read pipeline
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  snap_q, snap_d;
  logic              rd_pend_q, rd_pend_d;
  logic [FIFO_W-1:0] rd_data_q, rd_data_d;
  logic [FIFO_W-1:0] io_din_q, io_din_d;
  logic              io_rd_hit_q, io_rd_hit_d;
  logic              stop_q, stop_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    cnt_d       = dbg_cnt_load_i ? dbg_cnt_val_i : cnt_q + 1'b1;
    snap_d      = snap_q;
    rd_pend_d   = (rd_sel_w != RSEL_NONE);
    rd_data_d   = '0;
    io_rd_hit_d = rd_pend_q;
    io_din_d    = rd_pend_q ? rd_data_q : io_din_q;
    stop_d      = stop_q | (io_wr_w && (addr_w == IO_CLK));
    ovf_d       = ovf_q | (tx_req_w && tx_full_w);

    // Stage one captures the byte on the accepting edge so that the rx pop
    // and the snapshot happen together with the access; stage two presents
    // it to the CPU one edge later.
    case (rd_sel_w)
      RSEL_RX:   rd_data_d = rx_empty_w ? '0 : rx_head_w;
      RSEL_CNT0: begin
        snap_d    = cnt_q;
        rd_data_d = cnt_q[7:0];
      end
      RSEL_CNT1: rd_data_d = snap_q[15:8];
      RSEL_CNT2: rd_data_d = snap_q[23:16];
      RSEL_CNT3: rd_data_d = snap_q[31:24];
      default:   rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q       <= '0;
      snap_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_data_q   <= '0;
      io_din_q    <= '0;
      io_rd_hit_q <= 1'b0;
      stop_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (rdy_in) begin
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      rd_pend_q   <= rd_pend_d;
      rd_data_q   <= rd_data_d;
      io_din_q    <= io_din_d;
      io_rd_hit_q <= io_rd_hit_d;
      stop_q      <= stop_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.io_din    = io_din_q;
  assign bus.io_rd_hit = io_rd_hit_q;
  assign program_stop  = stop_q;
  assign tx_overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_io_responder
//  Description : Self-checking bench for mem_io_responder: a table of single
//                bus operations followed by hand-written multi-cycle
//                sequences (tx fill/overflow/drain, counter wrap, halt and
//                reset, enable freeze, rx fill).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        program_stop;
  logic        tx_overflow;
  logic        dbg_load;
  logic [31:0] dbg_val;

  int total = 0;
  int bad   = 0;

  mem_io_responder_if bus();

  mem_io_responder #(
    .TX_DEPTH    (16),
    .RX_DEPTH    (8),
    .FULL_MARGIN (4)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .bus            (bus),
    .program_stop   (program_stop),
    .tx_overflow_o  (tx_overflow),
    .dbg_cnt_load_i (dbg_load),
    .dbg_cnt_val_i  (dbg_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        rx_pre;
    logic [7:0]  rx_byte;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic        exp_hit;
    logic [7:0]  exp_din;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.mem_a    = 32'h0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'h00;
  endtask

  task automatic rx_push(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // One read with the two-edge latency: hit high for exactly one cycle.
  task automatic do_read(input logic [31:0] a, input logic [7:0] exp, input string nm);
    bus.mem_a  = a;
    bus.mem_wr = 1'b0;
    tick();
    idle();
    tick();
    chk({nm, " hit"}, bus.io_rd_hit, 1'b1);
    chk({nm, " din"}, bus.io_din, exp);
    tick();
    chk({nm, " hit_end"}, bus.io_rd_hit, 1'b0);
  endtask

  initial begin
    //           wr    addr          wdata  pre   rxb    txv   txd    hit   din
    vecs[0]  = '{1'b1, 32'h00030000, 8'h41, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 32'h00030000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 32'h00020000, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 32'h00030008, 8'h33, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 32'h00030000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 32'h00030000, 8'h00, 1'b1, 8'h7A, 1'b0, 8'h00, 1'b1, 8'h7A};
    vecs[6]  = '{1'b0, 32'h00030000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[7]  = '{1'b0, 32'h00030005, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[8]  = '{1'b0, 32'h00010000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 32'h0003000C, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[10] = '{1'b1, 32'hFFF30000, 8'h5A, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 32'h12330000, 8'h00, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b1, 8'hC3};

    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    dbg_load     = 1'b0;
    dbg_val      = 32'h0;
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle();
    @(negedge clk);

    // ---------------- reset state
    tick(); tick(); tick();
    chk("rst tx_valid", bus.tx_valid, 1'b0);
    chk("rst rx_ready", bus.rx_ready, 1'b1);
    chk("rst io_din", bus.io_din, 8'h00);
    chk("rst buf_full", bus.io_buffer_full, 1'b0);
    chk("rst rd_hit", bus.io_rd_hit, 1'b0);
    chk("rst stop", program_stop, 1'b0);
    chk("rst overflow", tx_overflow, 1'b0);
    rst_in = 1'b1;
    tick();

    // ---------------- table of single operations (tx_ready held high)
    for (int v = 0; v < NV; v++) begin
      if (vecs[v].rx_pre) rx_push(vecs[v].rx_byte);
      bus.mem_a    = vecs[v].addr;
      bus.mem_wr   = vecs[v].wr;
      bus.mem_dout = vecs[v].wdata;
      tick();
      chk($sformatf("v%0d tx_valid", v), bus.tx_valid, vecs[v].exp_txv);
      if (vecs[v].exp_txv) chk($sformatf("v%0d tx_data", v), bus.tx_data, vecs[v].exp_txd);
      idle();
      tick();
      chk($sformatf("v%0d rd_hit", v), bus.io_rd_hit, vecs[v].exp_hit);
      if (vecs[v].exp_hit) chk($sformatf("v%0d io_din", v), bus.io_din, vecs[v].exp_din);
      chk($sformatf("v%0d tx_drained", v), bus.tx_valid, 1'b0);
      tick();
      chk($sformatf("v%0d rd_hit_end", v), bus.io_rd_hit, 1'b0);
    end

    // ---------------- tx fill to threshold, full, overflow, then drain
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.mem_a    = 32'h00030000;
      bus.mem_wr   = 1'b1;
      bus.mem_dout = 8'(i + 1);
      tick();
      if (i == 10) chk("fill11 buf_full", bus.io_buffer_full, 1'b0);
      if (i == 11) chk("fill12 buf_full", bus.io_buffer_full, 1'b1);
      if (i == 15) chk("fill16 overflow", tx_overflow, 1'b0);
    end
    idle();
    chk("fill17 overflow", tx_overflow, 1'b1);
    chk("fill tx_valid", bus.tx_valid, 1'b1);
    chk("fill tx_data stable", bus.tx_data, 8'h01);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d tx_valid", i), bus.tx_valid, 1'b1);
      chk($sformatf("drain%0d tx_data", i), bus.tx_data, 8'(i + 1));
      tick();
    end
    chk("drain empty", bus.tx_valid, 1'b0);
    chk("drain buf_full", bus.io_buffer_full, 1'b0);
    chk("drain overflow sticky", tx_overflow, 1'b1);

    // ---------------- counter preload, snapshot bytes, wrap
    dbg_load = 1'b1;
    dbg_val  = 32'hFFFF_FFFE;
    tick();
    dbg_load  = 1'b0;
    bus.mem_a = 32'h00030004;
    tick();
    bus.mem_a = 32'h00030005;
    tick();
    chk("cnt b0 hit", bus.io_rd_hit, 1'b1);
    chk("cnt b0", bus.io_din, 8'hFE);
    bus.mem_a = 32'h00030006;
    tick();
    chk("cnt b1", bus.io_din, 8'hFF);
    bus.mem_a = 32'h00030007;
    tick();
    chk("cnt b2", bus.io_din, 8'hFF);
    idle();
    tick();
    chk("cnt b3 hit", bus.io_rd_hit, 1'b1);
    chk("cnt b3", bus.io_din, 8'hFF);
    bus.mem_a = 32'h00030004;
    tick();
    bus.mem_a = 32'h00030007;
    tick();
    chk("wrap b0", bus.io_din, 8'h03);
    idle();
    tick();
    chk("wrap b3", bus.io_din, 8'h00);
    tick();
    chk("wrap hit_end", bus.io_rd_hit, 1'b0);

    // ---------------- halt request, then reset with a read in flight
    bus.tx_ready = 1'b0;
    bus.mem_a    = 32'h00030004;
    bus.mem_wr   = 1'b1;
    bus.mem_dout = 8'h99;
    tick();
    idle();
    chk("halt stop", program_stop, 1'b1);
    chk("halt tx_valid", bus.tx_valid, 1'b1);
    chk("halt tx_data", bus.tx_data, 8'h00);
    rx_push(8'h99);
    rx_push(8'h98);
    bus.mem_a = 32'h00030000;
    tick();
    idle();
    rst_in = 1'b0;
    tick();
    chk("rstfly rd_hit", bus.io_rd_hit, 1'b0);
    chk("rstfly stop", program_stop, 1'b0);
    chk("rstfly tx_valid", bus.tx_valid, 1'b0);
    chk("rstfly overflow", tx_overflow, 1'b0);
    chk("rstfly rx_ready", bus.rx_ready, 1'b1);
    rst_in = 1'b1;
    tick();
    chk("rstfly rd_hit2", bus.io_rd_hit, 1'b0);
    do_read(32'h00030000, 8'h00, "rstfly rx_flushed");

    // ---------------- rdy_in low freezes everything
    rx_push(8'h44);
    dbg_load = 1'b1;
    dbg_val  = 32'h1234_5678;
    tick();
    dbg_load     = 1'b0;
    rdy_in       = 1'b0;
    bus.mem_a    = 32'h00030000;
    bus.mem_wr   = 1'b1;
    bus.mem_dout = 8'h22;
    tick();
    chk("frz wr hit", bus.io_rd_hit, 1'b0);
    bus.mem_wr = 1'b0;
    tick();
    chk("frz rd hit", bus.io_rd_hit, 1'b0);
    idle();
    tick();
    chk("frz rd hit2", bus.io_rd_hit, 1'b0);
    rdy_in = 1'b1;
    chk("frz no tx push", bus.tx_valid, 1'b0);
    do_read(32'h00030004, 8'h78, "frz counter");
    do_read(32'h00030000, 8'h44, "frz rx kept");

    // ---------------- rx fill to full, overflow attempt, read back
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rxfill%0d ready", i), bus.rx_ready, 1'b1);
      rx_push(8'(8'hA0 + i));
    end
    chk("rxfull ready", bus.rx_ready, 1'b0);
    rx_push(8'hFF);
    for (int i = 0; i < 8; i++) begin
      do_read(32'h00030000, 8'(8'hA0 + i), $sformatf("rxread%0d", i));
    end
    do_read(32'h00030000, 8'h00, "rxread empty");
    chk("rx ready again", bus.rx_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
